// File: rtl/pll_sup_if.sv
// Signal bundle between the PLL lock supervisor and the rPLL / downstream video logic.
interface pll_sup_if;
    logic        pll_lock;
    logic        clkdiv_tgl;
    logic        pll_reset;
    logic        sys_rst_n;
    logic        pll_good;
    logic        fault;
    logic [3:0]  retry_cnt;
    logic [15:0] freq_count;

    modport master (
        output pll_lock, clkdiv_tgl,
        input  pll_reset, sys_rst_n, pll_good, fault, retry_cnt, freq_count
    );

    modport slave (
        input  pll_lock, clkdiv_tgl,
        output pll_reset, sys_rst_n, pll_good, fault, retry_cnt, freq_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rPLL supervisor: holds RESET, qualifies LOCK by stability and CLKOUT frequency, retries with a bound.
// Optional macro PLL_SUP_RUN_MONITOR_EN keeps measuring frequency while in RUN.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES     = 32,
    parameter int unsigned LOCK_TIMEOUT       = 27000,
    parameter int unsigned LOCK_STABLE_CYCLES = 2700,
    parameter int unsigned WINDOW_CYCLES      = 27000,
    parameter int unsigned EXP_MIN            = 5044,
    parameter int unsigned EXP_MAX            = 5249,
    parameter int unsigned MAX_RETRIES        = 7
) (
    input  logic      clkin,
    input  logic      resetn,
    pll_sup_if.slave  bus
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > WINDOW_CYCLES) ? LOCK_STABLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef PLL_SUP_RUN_MONITOR_EN
    localparam bit RUN_MON = 1'b1;
`else
    localparam bit RUN_MON = 1'b0;
`endif

    typedef enum logic [2:0] {
        PLL_RST, WAIT_LOCK, STABLE, MEASURE, RUN, FAULT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        edge_cnt;
    logic [15:0]        edge_nxt;
    logic [1:0]         lock_sync;
    logic [2:0]         tgl_sync;
    logic               lock_s;
    logic               tgl_edge;
    logic               win_end;
    logic               win_upd;
    logic               in_range;
    logic               retry_req;
    logic               retry_last;
    logic [3:0]         retry_inc;

    logic               pll_reset_q;
    logic               sys_rst_n_q;
    logic               pll_good_q;
    logic               fault_q;
    logic [3:0]         retry_cnt_q;
    logic [15:0]        freq_count_q;

    // Synchronizers; the third toggle flop turns each divider toggle into a one-cycle edge
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_sync <= '0;
            tgl_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[0], bus.pll_lock};
            tgl_sync  <= {tgl_sync[1:0], bus.clkdiv_tgl};
        end
    end

    assign lock_s   = lock_sync[1];
    assign tgl_edge = tgl_sync[1] ^ tgl_sync[2];

    // Window arithmetic and retry decision; a lock drop always takes priority
    always_comb begin
        edge_nxt = edge_cnt;
        if (tgl_edge && (edge_cnt != 16'hFFFF)) edge_nxt = edge_cnt + 16'd1;
        win_end    = (cnt == CNT_W'(WINDOW_CYCLES - 1));
        in_range   = (edge_nxt >= 16'(EXP_MIN)) && (edge_nxt <= 16'(EXP_MAX));
        win_upd    = lock_s && win_end && ((state == MEASURE) || (RUN_MON && (state == RUN)));
        retry_last = ((retry_cnt_q + 4'd1) == 4'(MAX_RETRIES));
        retry_inc  = (retry_cnt_q == 4'hF) ? retry_cnt_q : retry_cnt_q + 4'd1;
        retry_req  = 1'b0;
        case (state)
            WAIT_LOCK: retry_req = !lock_s && (cnt == CNT_W'(LOCK_TIMEOUT - 1));
            MEASURE:   retry_req = !lock_s || (win_end && !in_range);
            RUN:       retry_req = !lock_s || (RUN_MON && win_end && !in_range);
            default:   retry_req = 1'b0;
        endcase
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state        <= PLL_RST;
            cnt          <= '0;
            edge_cnt     <= '0;
            pll_reset_q  <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            pll_good_q   <= 1'b0;
            fault_q      <= 1'b0;
            retry_cnt_q  <= '0;
            freq_count_q <= '0;
        end else begin
            if (win_upd) freq_count_q <= edge_nxt;
            if (retry_req) begin
                state       <= retry_last ? FAULT : PLL_RST;
                cnt         <= '0;
                edge_cnt    <= '0;
                pll_reset_q <= 1'b1;
                sys_rst_n_q <= 1'b0;
                pll_good_q  <= 1'b0;
                fault_q     <= retry_last;
                retry_cnt_q <= retry_inc;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                            state       <= WAIT_LOCK;
                            cnt         <= '0;
                            pll_reset_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                            state    <= MEASURE;
                            cnt      <= '0;
                            edge_cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (win_end) begin
                            state       <= RUN;
                            cnt         <= '0;
                            edge_cnt    <= '0;
                            sys_rst_n_q <= 1'b1;
                            pll_good_q  <= 1'b1;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            edge_cnt <= edge_nxt;
                        end
                    end
                    RUN: begin
                        if (RUN_MON && !win_end) begin
                            cnt      <= cnt + CNT_W'(1);
                            edge_cnt <= edge_nxt;
                        end else begin
                            cnt      <= '0;
                            edge_cnt <= '0;
                        end
                    end
                    FAULT: begin
                        pll_reset_q <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        pll_good_q  <= 1'b0;
                        fault_q     <= 1'b1;
                    end
                    default: state <= PLL_RST;
                endcase
            end
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.pll_good   = pll_good_q;
    assign bus.fault      = fault_q;
    assign bus.retry_cnt  = retry_cnt_q;
    assign bus.freq_count = freq_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic clk = 1'b0;
    logic resetn;
    int   period = 0;
    int   tcnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pll_sup_if bus ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(64), .LOCK_STABLE_CYCLES(16),
        .WINDOW_CYCLES(256), .EXP_MIN(40), .EXP_MAX(48), .MAX_RETRIES(3)
    ) dut (
        .clkin(clk),
        .resetn(resetn),
        .bus(bus)
    );

    // Divider toggle model: flips every 'period' clkin cycles, idle when period is 0
    initial begin
        bus.clkdiv_tgl = 1'b0;
        forever begin
            @(negedge clk);
            if (period > 0) begin
                if (tcnt + 1 >= period) begin
                    bus.clkdiv_tgl = ~bus.clkdiv_tgl;
                    tcnt = 0;
                end else begin
                    tcnt++;
                end
            end
        end
    end

    typedef struct {
        bit   rst;
        logic lock;
        int   per;
        int   cyc;
        logic ex_prst;
        logic ex_sys;
        logic ex_good;
        logic ex_fault;
        int   ex_retry;
        int   fmin;
        int   fmax;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic do_reset(input logic lock, input int per);
        resetn = 1'b0;
        bus.pll_lock = lock;
        period = per;
        repeat (3) @(negedge clk);
        chk("rst_pll_reset", int'(bus.pll_reset), 1);
        chk("rst_sys_rst_n", int'(bus.sys_rst_n), 0);
        chk("rst_pll_good", int'(bus.pll_good), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_retry_cnt", int'(bus.retry_cnt), 0);
        chk("rst_freq_count", int'(bus.freq_count), 0);
        resetn = 1'b1;
    endtask

    task automatic wait_good(input logic val, input int maxc, output int n);
        n = 0;
        while (bus.pll_good !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        bus.pll_lock = 1'b0;

        // Normal qualification: lock after cycle 10, toggle every 6 clkin
        vecs[0]  = '{1, 0, 6,   3, 1, 0, 0, 0, 0,  0,  0};
        vecs[1]  = '{0, 0, 6,   1, 0, 0, 0, 0, 0,  0,  0};
        vecs[2]  = '{0, 0, 6,   6, 0, 0, 0, 0, 0,  0,  0};
        vecs[3]  = '{0, 1, 6,  19, 0, 0, 0, 0, 0,  0,  0};
        vecs[4]  = '{0, 1, 6, 255, 0, 0, 0, 0, 0,  0,  0};
        vecs[5]  = '{0, 1, 6,   1, 0, 1, 1, 0, 0, 42, 43};
        vecs[6]  = '{0, 1, 6,  20, 0, 1, 1, 0, 0, 42, 43};
        // Frequency too high (64 edges/window): three failed windows then FAULT
        vecs[7]  = '{1, 1, 4, 277, 1, 0, 0, 0, 1, 64, 64};
        vecs[8]  = '{0, 1, 4, 553, 0, 0, 0, 0, 2, 64, 64};
        vecs[9]  = '{0, 1, 4,   1, 1, 0, 0, 1, 3, 64, 64};
        vecs[10] = '{0, 1, 4, 500, 1, 0, 0, 1, 3, 64, 64};
        // Lock never asserted: 64-cycle timeout per attempt
        vecs[11] = '{1, 0, 0,  67, 0, 0, 0, 0, 0,  0,  0};
        vecs[12] = '{0, 0, 0,   1, 1, 0, 0, 0, 1,  0,  0};
        vecs[13] = '{0, 0, 0,  67, 0, 0, 0, 0, 1,  0,  0};
        vecs[14] = '{0, 0, 0,   1, 1, 0, 0, 0, 2,  0,  0};
        vecs[15] = '{0, 0, 0,  67, 0, 0, 0, 0, 2,  0,  0};
        vecs[16] = '{0, 0, 0,   1, 1, 0, 0, 1, 3,  0,  0};
        vecs[17] = '{0, 0, 0, 200, 1, 0, 0, 1, 3,  0,  0};

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].lock, vecs[i].per);
            end else begin
                bus.pll_lock = vecs[i].lock;
                period = vecs[i].per;
            end
            repeat (vecs[i].cyc) @(negedge clk);
            chk($sformatf("v%0d_pll_reset", i), int'(bus.pll_reset), int'(vecs[i].ex_prst));
            chk($sformatf("v%0d_sys_rst_n", i), int'(bus.sys_rst_n), int'(vecs[i].ex_sys));
            chk($sformatf("v%0d_pll_good", i), int'(bus.pll_good), int'(vecs[i].ex_good));
            chk($sformatf("v%0d_fault", i), int'(bus.fault), int'(vecs[i].ex_fault));
            chk($sformatf("v%0d_retry_cnt", i), int'(bus.retry_cnt), vecs[i].ex_retry);
            chk_rng($sformatf("v%0d_freq_count", i), int'(bus.freq_count), vecs[i].fmin, vecs[i].fmax);
        end

        // One-cycle lock glitch at stable count 10 restarts qualification without a retry
        do_reset(1'b1, 6);
        repeat (15) @(negedge clk);
        bus.pll_lock = 1'b0;
        @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (261) @(negedge clk);
        chk("glitch_no_run_e277", int'(bus.pll_good), 0);
        repeat (13) @(negedge clk);
        chk("glitch_no_run_e290", int'(bus.pll_good), 0);
        @(negedge clk);
        chk("glitch_run_e291", int'(bus.pll_good), 1);
        chk("glitch_retry_cnt", int'(bus.retry_cnt), 0);

        // Lock loss in RUN: sys_rst_n drops on the 3rd edge, then requalify
        do_reset(1'b1, 6);
        repeat (277) @(negedge clk);
        chk("drop_run_before", int'(bus.pll_good), 1);
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_sys_edge2", int'(bus.sys_rst_n), 1);
        @(negedge clk);
        chk("drop_sys_edge3", int'(bus.sys_rst_n), 0);
        chk("drop_retry_cnt", int'(bus.retry_cnt), 1);
        chk("drop_pll_reset", int'(bus.pll_reset), 1);
        chk("drop_pll_good", int'(bus.pll_good), 0);
        bus.pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("drop_rst_hold4", int'(bus.pll_reset), 1);
        @(negedge clk);
        chk("drop_rst_release", int'(bus.pll_reset), 0);
        wait_good(1'b1, 400, n);
        chk("drop_requal_run", int'(bus.pll_good), 1);
        chk("drop_requal_sys", int'(bus.sys_rst_n), 1);
        chk("drop_requal_retry", int'(bus.retry_cnt), 1);
        chk_rng("drop_requal_freq", int'(bus.freq_count), 42, 43);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_pll_reset", int'(bus.pll_reset), 1);
        chk("async_sys_rst_n", int'(bus.sys_rst_n), 0);
        chk("async_pll_good", int'(bus.pll_good), 0);
        chk("async_retry_cnt", int'(bus.retry_cnt), 0);
        @(negedge clk);

        // Frequency shift while in RUN
        do_reset(1'b1, 6);
        repeat (277) @(negedge clk);
        chk("mon_run_entry", int'(bus.pll_good), 1);
        period = 4;
`ifdef PLL_SUP_RUN_MONITOR_EN
        wait_good(1'b0, 300, n);
        chk("mon_exit_run", int'(bus.pll_good), 0);
        chk("mon_retry_cnt", int'(bus.retry_cnt), 1);
        chk_rng("mon_freq_count", int'(bus.freq_count), 63, 65);
`else
        repeat (600) @(negedge clk);
        chk("nomon_stay_run", int'(bus.pll_good), 1);
        chk("nomon_retry_cnt", int'(bus.retry_cnt), 0);
        chk_rng("nomon_freq_frozen", int'(bus.freq_count), 42, 43);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
